// File: rtl/fetch_queue_gen_if.sv
// Fetch queue bus: groups the prefetch push port, the I-cache request/response
// strobes and the decode window into one bundle.
//   slave  : seen from the fetch queue (consumes push/response/accept, drives window)
//   master : seen from the environment (prefetch, I-cache, decode)
// Signals:
//   flush, in_valid/in_ready, in_pc, in_bubble, in_ex, in_exccode  - push side
//   req_issued, resp_valid, resp_data, resp_tlb_ex, resp_exccode   - I-cache side
//   out_valid, out_inst, out_pc, out_bubble, out_ex, out_exccode,
//   out_accept_cnt                                                 - decode side
//   count, outstanding                                             - status
interface fetch_queue_gen_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int MAX_OUT = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int ACC_W = $clog2(DEC_W + 1);

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [32*FETCH_W-1:0]  in_pc;
  logic [FETCH_W-1:0]     in_bubble;
  logic [FETCH_W-1:0]     in_ex;
  logic [5*FETCH_W-1:0]   in_exccode;
  logic                   req_issued;
  logic                   resp_valid;
  logic [32*FETCH_W-1:0]  resp_data;
  logic                   resp_tlb_ex;
  logic [4:0]             resp_exccode;
  logic [DEC_W-1:0]       out_valid;
  logic [32*DEC_W-1:0]    out_inst;
  logic [32*DEC_W-1:0]    out_pc;
  logic [DEC_W-1:0]       out_bubble;
  logic [DEC_W-1:0]       out_ex;
  logic [5*DEC_W-1:0]     out_exccode;
  logic [ACC_W-1:0]       out_accept_cnt;
  logic [CNT_W-1:0]       count;
  logic [OUT_W-1:0]       outstanding;

  modport slave (
    input  flush, in_valid, in_pc, in_bubble, in_ex, in_exccode,
           req_issued, resp_valid, resp_data, resp_tlb_ex, resp_exccode,
           out_accept_cnt,
    output in_ready, out_valid, out_inst, out_pc, out_bubble, out_ex,
           out_exccode, count, outstanding
  );

  modport master (
    output flush, in_valid, in_pc, in_bubble, in_ex, in_exccode,
           req_issued, resp_valid, resp_data, resp_tlb_ex, resp_exccode,
           out_accept_cnt,
    input  in_ready, out_valid, out_inst, out_pc, out_bubble, out_ex,
           out_exccode, count, outstanding
  );
endinterface

// File: rtl/fetch_queue_gen.sv
// Fetch queue between prefetch and decode.
// Circular store of DEPTH instruction slots, filled a fetch group (FETCH_W
// slots) at a time. A group is either completed immediately (prefetch
// exception) or waits for an in-order I-cache response. Decode sees a window of
// DEC_W slots at the head and may take any prefix of the valid ones. After a
// flush, a cancel counter swallows the responses of requests that were still
// in flight.
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - fetch_queue_gen_if.slave (push, I-cache, decode window, status)
module fetch_queue_gen #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  fetch_queue_gen_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int NGRP  = DEPTH / FETCH_W;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  // Control state (reset)
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] outst_q;
  logic [OUT_W-1:0] cancel_q;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] done_q;

  // Slot payload (not reset; only observed through vld_q/done_q)
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [4:0]       code_q [DEPTH];
  logic [DEPTH-1:0] bubble_q;
  logic [DEPTH-1:0] ex_q;

  logic             in_ready;
  logic             push;
  logic             grp_ex;
  logic             resp_fill;
  logic [NGRP-1:0]  grp_wait;
  logic             fill_found;
  logic [GRP_W-1:0] fill_grp;
  logic [PTR_W-1:0] win_idx  [DEC_W];
  logic [PTR_W-1:0] tail_idx [FETCH_W];
  logic [PTR_W-1:0] fill_idx [FETCH_W];
  logic             run;

  logic [DEC_W-1:0]    out_valid;
  logic [32*DEC_W-1:0] out_inst;
  logic [32*DEC_W-1:0] out_pc;
  logic [DEC_W-1:0]    out_bubble;
  logic [DEC_W-1:0]    out_ex;
  logic [5*DEC_W-1:0]  out_exccode;

  // Registered count only, so a pop in the same cycle never frees room early.
  assign in_ready  = (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign push      = bus.in_valid & in_ready & ~bus.flush;
  assign grp_ex    = |bus.in_ex;
  assign resp_fill = bus.resp_valid & ~bus.flush & (cancel_q == '0) & fill_found;

  // Groups are always written group-aligned (tail starts at 0 and steps by
  // FETCH_W), and a WAIT group can never be partly popped, so checking the
  // first slot of each group is enough.
  always_comb begin
    grp_wait = '0;
    for (int g = 0; g < NGRP; g++)
      grp_wait[g] = vld_q[g*FETCH_W] & ~done_q[g*FETCH_W];
  end

  // Oldest waiting group: scan group slots in age order starting at the head group.
  always_comb begin
    fill_found = 1'b0;
    fill_grp   = '0;
    for (int k = 0; k < NGRP; k++) begin
      if (!fill_found && grp_wait[GRP_W'((int'(head_q) / FETCH_W + k) % NGRP)]) begin
        fill_found = 1'b1;
        fill_grp   = GRP_W'((int'(head_q) / FETCH_W + k) % NGRP);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEC_W; i++)
      win_idx[i] = PTR_W'(int'(head_q) + i);
    for (int j = 0; j < FETCH_W; j++) begin
      tail_idx[j] = PTR_W'(int'(tail_q) + j);
      fill_idx[j] = PTR_W'(int'(fill_grp) * FETCH_W + j);
    end
  end

  // Decode window: valid stops at the first slot that is empty or still waiting.
  always_comb begin
    out_valid   = '0;
    out_inst    = '0;
    out_pc      = '0;
    out_bubble  = '0;
    out_ex      = '0;
    out_exccode = '0;
    run         = 1'b1;
    for (int i = 0; i < DEC_W; i++) begin
      run = run & vld_q[win_idx[i]] & done_q[win_idx[i]] & (CNT_W'(i) < count_q);
      out_valid[i]        = run;
      out_inst[32*i +: 32] = inst_q[win_idx[i]];
      out_pc[32*i +: 32]   = pc_q[win_idx[i]];
      out_bubble[i]       = bubble_q[win_idx[i]];
      out_ex[i]           = ex_q[win_idx[i]];
      out_exccode[5*i +: 5] = code_q[win_idx[i]];
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_inst    = out_inst;
  assign bus.out_pc      = out_pc;
  assign bus.out_bubble  = out_bubble;
  assign bus.out_ex      = out_ex;
  assign bus.out_exccode = out_exccode;
  assign bus.count       = count_q;
  assign bus.outstanding = outst_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      cancel_q <= '0;
      vld_q    <= '0;
      done_q   <= '0;
    end else if (bus.flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      done_q   <= '0;
      // Every request still live (including one issued this cycle) must be
      // swallowed; a response this cycle answers one of them. Folding in an
      // existing cancel_cnt keeps back-to-back flushes consistent.
      cancel_q <= OUT_W'(int'(cancel_q) + int'(outst_q) + int'(bus.req_issued)
                         - int'(bus.resp_valid));
      outst_q  <= '0;
    end else begin
      head_q  <= PTR_W'(int'(head_q) + int'(bus.out_accept_cnt));
      if (push)
        tail_q <= PTR_W'(int'(tail_q) + FETCH_W);
      count_q <= CNT_W'(int'(count_q) + (push ? FETCH_W : 0) - int'(bus.out_accept_cnt));

      if (cancel_q != '0) begin
        cancel_q <= cancel_q - OUT_W'(bus.resp_valid);
        outst_q  <= outst_q + OUT_W'(bus.req_issued);
      end else begin
        outst_q  <= OUT_W'(int'(outst_q) + int'(bus.req_issued) - int'(bus.resp_valid));
      end

      // Pop, push and fill always touch disjoint slots.
      for (int i = 0; i < DEC_W; i++) begin
        if (i < int'(bus.out_accept_cnt)) begin
          vld_q[win_idx[i]]  <= 1'b0;
          done_q[win_idx[i]] <= 1'b0;
        end
      end
      if (push) begin
        for (int j = 0; j < FETCH_W; j++) begin
          vld_q[tail_idx[j]]  <= 1'b1;
          done_q[tail_idx[j]] <= grp_ex;
        end
      end
      if (resp_fill) begin
        for (int j = 0; j < FETCH_W; j++)
          done_q[fill_idx[j]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int j = 0; j < FETCH_W; j++) begin
        pc_q[tail_idx[j]]     <= bus.in_pc[32*j +: 32];
        inst_q[tail_idx[j]]   <= '0;
        bubble_q[tail_idx[j]] <= bus.in_bubble[j];
        ex_q[tail_idx[j]]     <= bus.in_ex[j];
        code_q[tail_idx[j]]   <= bus.in_exccode[5*j +: 5];
      end
    end
    if (resp_fill) begin
      for (int j = 0; j < FETCH_W; j++) begin
        inst_q[fill_idx[j]] <= bus.resp_data[32*j +: 32];
        if (bus.resp_tlb_ex) begin
          ex_q[fill_idx[j]]   <= 1'b1;
          code_q[fill_idx[j]] <= bus.resp_exccode;
        end
      end
    end
  end

  // A live response must have a waiting group to land in.
  a_resp_has_target: assert property (@(posedge clk) disable iff (!resetn)
    (bus.resp_valid && !bus.flush && cancel_q == '0) |-> fill_found);

  // Decode may only consume slots it was shown as valid.
  a_accept_prefix: assert property (@(posedge clk) disable iff (!resetn)
    int'(bus.out_accept_cnt) <= $countones(out_valid));

endmodule
